// File: rtl/instr_encoder_loader_pkg.sv
// Shared RV32 encoding constants and request codes for the instruction loader.
// The decoder imports the same constants so that the encoder and decoder agree.
package instr_encoder_loader_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_ADD  = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  // addi x0,x0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    REQ_LB      = 3'd0,
    REQ_LW      = 3'd1,
    REQ_SB      = 3'd2,
    REQ_SW      = 3'd3,
    REQ_ADD     = 3'd4,
    REQ_SUB     = 3'd5,
    REQ_MUL     = 3'd6,
    REQ_ILLEGAL = 3'd7
  } req_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1
`ifdef ENC_NOP_PAD_EN
    ,ST_PAD  = 2'd2
`endif
  } state_e;

  function automatic logic is_load(input logic [2:0] op);
    return (op == REQ_LB) || (op == REQ_LW);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_encode.sv
// Combinational RV32 encoder: abstract request fields in, 32-bit machine word out.
// Unused fields of a format are simply not placed into the word.
module instr_encode
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      REQ_LB:  word = {imm, rs1, F3_BYTE, rd, OP_LOAD};
      REQ_LW:  word = {imm, rs1, F3_WORD, rd, OP_LOAD};
      REQ_SB:  word = {imm[11:5], rs2, rs1, F3_BYTE, imm[4:0], OP_STORE};
      REQ_SW:  word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_STORE};
      REQ_ADD: word = {F7_ADD, rs2, rs1, F3_ADD, rd, OP_RTYPE};
      REQ_SUB: word = {F7_SUB, rs2, rs1, F3_ADD, rd, OP_RTYPE};
      REQ_MUL: word = {F7_MUL, rs2, rs1, F3_ADD, rd, OP_RTYPE};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot-time program loader: encodes requests and writes them to sequential imem words.
// Optional load-use NOP padding after loads is enabled with `define ENC_NOP_PAD_EN.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int AW        = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [4:0]    req_rd,
  input  logic [4:0]    req_rs1,
  input  logic [4:0]    req_rs2,
  input  logic [11:0]   req_imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  input  logic          imem_ack,
  output logic          err_illegal,
  output logic          full,
  output logic [AW:0]   word_count
);

  localparam logic [AW-1:0] ADDR_BASE = AW'(BASE_ADDR);
  localparam logic [AW-1:0] ADDR_LAST = '1;

  state_e        state_reg, state_next;
  logic          ready_reg, ready_next;
  logic          we_reg, we_next;
  logic          err_reg, err_next;
  logic          full_reg, full_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [31:0]   wdata_reg, wdata_next;
  logic [AW:0]   count_reg, count_next;
  logic [31:0]   enc_word;
  logic          enc_illegal;
  logic          accept;
`ifdef ENC_NOP_PAD_EN
  logic          load_reg, load_next;
`endif

  instr_encode u_encode (
    .op      (req_op),
    .rd      (req_rd),
    .rs1     (req_rs1),
    .rs2     (req_rs2),
    .imm     (req_imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign accept = (state_reg == ST_IDLE) && req_valid && ready_reg;

  always_comb begin
    state_next = state_reg;
    err_next   = 1'b0;
    full_next  = full_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    count_next = count_reg;
`ifdef ENC_NOP_PAD_EN
    load_next  = load_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (enc_illegal) begin
            err_next = 1'b1;
          end else begin
            wdata_next = enc_word;
            state_next = ST_WRITE;
`ifdef ENC_NOP_PAD_EN
            load_next  = is_load(req_op);
`endif
          end
        end
      end
      // WRITE and PAD share the write handshake; ack is only honoured here.
      default: begin
        if (imem_ack) begin
          count_next = count_reg + 1'b1;
          state_next = ST_IDLE;
          if (addr_reg == ADDR_LAST) begin
            full_next = 1'b1;
          end else begin
            addr_next = addr_reg + 1'b1;
          end
`ifdef ENC_NOP_PAD_EN
          if ((state_reg == ST_WRITE) && load_reg && (addr_reg != ADDR_LAST)) begin
            state_next = ST_PAD;
            wdata_next = NOP_WORD;
          end
`endif
        end
      end
    endcase
    we_next = (state_next != ST_IDLE);
    // Ready is withheld for the cycle after a write completes, giving 3 cycles per word.
    ready_next = (state_reg == ST_IDLE) && (state_next == ST_IDLE) && !full_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      ready_reg <= 1'b0;
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
      full_reg  <= 1'b0;
      addr_reg  <= ADDR_BASE;
      wdata_reg <= '0;
      count_reg <= '0;
`ifdef ENC_NOP_PAD_EN
      load_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      ready_reg <= ready_next;
      we_reg    <= we_next;
      err_reg   <= err_next;
      full_reg  <= full_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      count_reg <= count_next;
`ifdef ENC_NOP_PAD_EN
      load_reg  <= load_next;
`endif
    end
  end

  assign req_ready   = ready_reg;
  assign imem_we     = we_reg;
  assign imem_addr   = addr_reg;
  assign imem_wdata  = wdata_reg;
  assign err_illegal = err_reg;
  assign full        = full_reg;
  assign word_count  = count_reg;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: an AW=8 instance for encoding/handshake
// checks and an AW=2 instance for the full/no-wrap and mid-write reset cases.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, reset_b;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [11:0] req_imm;
  logic        imem_ack;

  logic        ready_a, we_a, err_a, full_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic [8:0]  count_a;

  logic        ready_b, we_b, err_b, full_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  count_b;

  int tests = 0;
  int fails = 0;

  instr_encoder_loader #(.AW(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset(reset_a), .req_valid(req_valid), .req_ready(ready_a),
    .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_imm(req_imm), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
    .imem_ack(imem_ack), .err_illegal(err_a), .full(full_a), .word_count(count_a)
  );

  instr_encoder_loader #(.AW(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .reset(reset_b), .req_valid(req_valid), .req_ready(ready_b),
    .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_imm(req_imm), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
    .imem_ack(imem_ack), .err_illegal(err_b), .full(full_b), .word_count(count_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic use_b);
    if (use_b) reset_b = 1'b0; else reset_a = 1'b0;
    tick();
    tick();
    if (use_b) reset_b = 1'b1; else reset_a = 1'b1;
  endtask

  // Waits for ready, then presents one request for a single cycle.
  task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [11:0] imm, input logic use_b);
    int n = 0;
    while (!(use_b ? ready_b : ready_a) && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 20) begin
      fails++;
      $display("FAIL send_ready: req_ready=0 after %0d cycles, expected 1", n);
    end
    req_valid = 1'b1;
    req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    tick();
    req_valid = 1'b0;
  endtask

  // Waits for imem_we, holds ack low for 'delay' cycles, then acks once.
  task automatic take_write(input int delay, input logic use_b, output logic [31:0] data,
                            output logic [7:0] addr, output int we_cycles);
    int n = 0;
    we_cycles = 0;
    while (!(use_b ? we_b : we_a) && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (!(use_b ? we_b : we_a)) begin
      fails++;
      $display("FAIL write_start: imem_we=0 after %0d cycles, expected 1", n);
    end
    data = use_b ? wdata_b : wdata_a;
    addr = use_b ? {6'b0, addr_b} : addr_a;
    for (int i = 0; i < delay; i++) begin
      if (use_b ? we_b : we_a) we_cycles++;
      tick();
      tests++;
      if ((use_b ? wdata_b : wdata_a) !== data || (use_b ? {6'b0, addr_b} : addr_a) !== addr) begin
        fails++;
        $display("FAIL write_stable: wdata/addr changed while waiting for ack (addr %0d data %h)", addr, data);
      end
    end
    imem_ack = 1'b1;
    if (use_b ? we_b : we_a) we_cycles++;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_a = 1'b0;
    tick();
    tick();
    tests++;
    if (ready_a !== 1'b0 || we_a !== 1'b0 || addr_a !== 8'd0 || wdata_a !== 32'd0 ||
        err_a !== 1'b0 || full_a !== 1'b0 || count_a !== 9'd0) begin
      fails++;
      $display("FAIL reset_state: ready=%b we=%b addr=%0d wdata=%h err=%b full=%b count=%0d, expected all 0",
               ready_a, we_a, addr_a, wdata_a, err_a, full_a, count_a);
    end
    reset_a = 1'b1;
    tick();
    tests++;
    if (ready_a !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: req_ready=%b after release, expected 1", ready_a);
    end
  endtask

  task automatic test_load_word();
    logic [31:0] d;
    logic [7:0]  a;
    int          wc;
    do_reset(1'b0);
    send(3'd1, 5'd5, 5'd2, 5'd0, 12'd8, 1'b0);
    take_write(2, 1'b0, d, a, wc);
    tests++;
    if (d !== 32'h0081_2283 || a !== 8'd0) begin
      fails++;
      $display("FAIL lw_word: got %h @%0d, expected 00812283 @0", d, a);
    end
    tests++;
    if (wc !== 3) begin
      fails++;
      $display("FAIL lw_we_cycles: imem_we high %0d cycles, expected 3", wc);
    end
`ifdef ENC_NOP_PAD_EN
    take_write(0, 1'b0, d, a, wc);
    tests++;
    if (d !== 32'h0000_0013 || a !== 8'd1) begin
      fails++;
      $display("FAIL lw_pad: got %h @%0d, expected 00000013 @1", d, a);
    end
    tests++;
    if (we_a !== 1'b0 || count_a !== 9'd2 || addr_a !== 8'd2) begin
      fails++;
      $display("FAIL lw_after_pad: we=%b count=%0d addr=%0d, expected 0 2 2", we_a, count_a, addr_a);
    end
`else
    tests++;
    if (we_a !== 1'b0 || count_a !== 9'd1 || addr_a !== 8'd1) begin
      fails++;
      $display("FAIL lw_after_ack: we=%b count=%0d addr=%0d, expected 0 1 1", we_a, count_a, addr_a);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0]  a;
    int          wc;
    logic [31:0] exp_words [3];
    exp_words[0] = 32'h0020_81B3;
    exp_words[1] = 32'h4020_81B3;
    exp_words[2] = 32'h0220_81B3;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      send(3'(4 + i), 5'd3, 5'd1, 5'd2, 12'd0, 1'b0);
      take_write(0, 1'b0, d, a, wc);
      tests++;
      if (d !== exp_words[i] || a !== 8'(i)) begin
        fails++;
        $display("FAIL rtype_%0d: got %h @%0d, expected %h @%0d", i, d, a, exp_words[i], i);
      end
    end
    tests++;
    if (count_a !== 9'd3 || addr_a !== 8'd3) begin
      fails++;
      $display("FAIL rtype_count: count=%0d addr=%0d, expected 3 3", count_a, addr_a);
    end
  endtask

  task automatic test_stores();
    logic [31:0] d;
    logic [7:0]  a;
    int          wc;
    do_reset(1'b0);
    send(3'd3, 5'd0, 5'd2, 5'd5, 12'd12, 1'b0);
    take_write(1, 1'b0, d, a, wc);
    tests++;
    if (d !== 32'h0051_2623 || a !== 8'd0) begin
      fails++;
      $display("FAIL sw_word: got %h @%0d, expected 00512623 @0", d, a);
    end
    send(3'd2, 5'd0, 5'd2, 5'd5, 12'hFFF, 1'b0);
    take_write(0, 1'b0, d, a, wc);
    tests++;
    if (d !== 32'hFE51_0FA3 || a !== 8'd1) begin
      fails++;
      $display("FAIL sb_word: got %h @%0d, expected fe510fa3 @1", d, a);
    end
  endtask

  task automatic test_illegal();
    do_reset(1'b0);
    send(3'd7, 5'd1, 5'd1, 5'd1, 12'd0, 1'b0);
    tests++;
    if (err_a !== 1'b1 || we_a !== 1'b0 || ready_a !== 1'b1) begin
      fails++;
      $display("FAIL illegal_pulse: err=%b we=%b ready=%b, expected 1 0 1", err_a, we_a, ready_a);
    end
    tick();
    tests++;
    if (err_a !== 1'b0 || we_a !== 1'b0 || count_a !== 9'd0) begin
      fails++;
      $display("FAIL illegal_after: err=%b we=%b count=%0d, expected 0 0 0", err_a, we_a, count_a);
    end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    tests++;
    if (count_a !== 9'd0 || addr_a !== 8'd0 || we_a !== 1'b0 || ready_a !== 1'b1) begin
      fails++;
      $display("FAIL stray_ack: count=%0d addr=%0d we=%b ready=%b, expected 0 0 0 1",
               count_a, addr_a, we_a, ready_a);
    end
  endtask

`ifdef ENC_NOP_PAD_EN
  task automatic test_nop_pad();
    logic [31:0] d;
    logic [7:0]  a;
    int          wc;
    do_reset(1'b0);
    send(3'd0, 5'd1, 5'd0, 5'd0, 12'd0, 1'b0);
    take_write(0, 1'b0, d, a, wc);
    tests++;
    if (d !== 32'h0000_0083 || a !== 8'd0) begin
      fails++;
      $display("FAIL lb_word: got %h @%0d, expected 00000083 @0", d, a);
    end
    take_write(1, 1'b0, d, a, wc);
    tests++;
    if (d !== 32'h0000_0013 || a !== 8'd1 || count_a !== 9'd2) begin
      fails++;
      $display("FAIL lb_pad: got %h @%0d count=%0d, expected 00000013 @1 count=2", d, a, count_a);
    end
  endtask
`endif

  task automatic test_full_and_reset();
    logic [31:0] d;
    logic [7:0]  a;
    int          wc;
    logic        saw_we;
    reset_a = 1'b0;
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      send(3'd4, 5'd3, 5'd1, 5'd2, 12'd0, 1'b1);
      take_write(0, 1'b1, d, a, wc);
      tests++;
      if (a !== 8'(i)) begin
        fails++;
        $display("FAIL full_addr_%0d: got %0d, expected %0d", i, a, i);
      end
    end
    tests++;
    if (full_b !== 1'b1 || count_b !== 3'd4 || addr_b !== 2'd3) begin
      fails++;
      $display("FAIL full_set: full=%b count=%0d addr=%0d, expected 1 4 3", full_b, count_b, addr_b);
    end
    saw_we = 1'b0;
    req_valid = 1'b1;
    req_op = 3'd4;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (we_b || ready_b) saw_we = 1'b1;
    end
    req_valid = 1'b0;
    tests++;
    if (saw_we !== 1'b0 || addr_b !== 2'd3 || count_b !== 3'd4) begin
      fails++;
      $display("FAIL full_block: saw we/ready=%b addr=%0d count=%0d, expected 0 3 4", saw_we, addr_b, count_b);
    end
    do_reset(1'b1);
    send(3'd5, 5'd3, 5'd1, 5'd2, 12'd0, 1'b1);
    take_write(0, 1'b1, d, a, wc);
    send(3'd6, 5'd3, 5'd1, 5'd2, 12'd0, 1'b1);
    tests++;
    if (we_b !== 1'b1 || addr_b !== 2'd1 || full_b !== 1'b0) begin
      fails++;
      $display("FAIL midwrite_setup: we=%b addr=%0d full=%b, expected 1 1 0", we_b, addr_b, full_b);
    end
    reset_b = 1'b0;
    tick();
    reset_b = 1'b1;
    tests++;
    if (we_b !== 1'b0 || addr_b !== 2'd0 || full_b !== 1'b0 || count_b !== 3'd0 || wdata_b !== 32'd0) begin
      fails++;
      $display("FAIL midwrite_reset: we=%b addr=%0d full=%b count=%0d wdata=%h, expected 0 0 0 0 0",
               we_b, addr_b, full_b, count_b, wdata_b);
    end
  endtask

  initial begin
    reset_a = 1'b0; reset_b = 1'b0;
    req_valid = 1'b0; req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    imem_ack = 1'b0;
    test_reset();
    test_load_word();
    test_back_to_back();
    test_stores();
    test_illegal();
`ifdef ENC_NOP_PAD_EN
    test_nop_pad();
`endif
    test_full_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
